aes_sbox_array: RTL and testbench
=================================

Name: aes_sbox_array

Overview:
Multi-lane, pipelined AES byte-substitution unit. It applies either the forward S-box (SubBytes) or the inverse S-box (InvSubBytes) from FIPS-197 to LANES bytes per beat. Mode is selectable per beat. It uses a two-stage valid/ready pipeline with full-throughput backpressure and sits between the round-state register and ShiftRows/InvShiftRows in the round datapath.

Parameters:
LANES, 4, number of independent byte lanes per beat (1..16; 16 = full 128-bit state)
TAG_W, 4, width of sideband tag carried alongside each beat (>=1)

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous active-high reset
flush  input  1  synchronous pipeline clear; drops all in-flight beats
in_valid  input  1  input beat valid
in_ready  output  1  unit accepts the beat this cycle
in_mode  input  1  0 = forward S-box, 1 = inverse S-box
in_data  input  8*LANES  lane i occupies bits [8i+7:8i]
in_tag  input  TAG_W  sideband, passed through unmodified
out_valid  output  1  output beat valid
out_ready  input  1  downstream accepts the output beat
out_data  output  8*LANES  substituted bytes, same lane mapping as in_data
out_mode  output  1  mode the beat was processed with
out_tag  output  TAG_W  tag of the beat
occupancy  output  2  number of beats held in the pipeline (0..2)

Behaviour:
- Reset, asynchronous on rst=1:
  - s1_valid, s2_valid = 0; all data, mode and tag registers = 0.
  - Outputs: out_valid=0, out_data=0, out_mode=0, out_tag=0, occupancy=0.
  - in_ready=1 as soon as rst deasserts, because it is derived from the valids.
- Stage 1 (S1) registers in_data, in_mode and in_tag.
- Stage 2 (S2) registers the lookup result of S1: per lane, SBOX(byte) when mode=0, INV_SBOX(byte) when mode=1.
- Outputs are driven directly from the S2 registers; there is no combinational path from in_data to out_data.
- Enables:
  - s2_en = !s2_valid | out_ready
  - s1_en = !s1_valid | s2_en
  - in_ready = s1_en
  - in_ready depends combinationally on out_ready; this is accepted.
- Transfer rules:
  - Input handshake = in_valid & in_ready.
  - Output handshake = out_valid & out_ready.
  - When s1_en=1: s1_valid <= in_valid. S1 data registers load only when in_valid=1.
  - When s2_en=1: s2_valid <= s1_valid. S2 registers load only when s1_valid=1.
  - When an enable is 0, the stage holds.
- Latency and throughput:
  - Latency is 2 cycles from the accepting edge to out_valid=1 when unstalled.
  - Sustained throughput is one beat per cycle with out_ready held at 1.
- Backpressure:
  - With out_ready=0 and both stages full: in_ready=0, and out_data, out_mode and out_tag are held stable.
  - When out_ready rises, one beat drains per cycle and in_ready=1 in that same cycle.
  - Beats are never dropped or duplicated, and order is preserved.
- Mode is carried per beat. Consecutive beats may alternate mode with no bubble.
- flush (synchronous, priority over all other updates):
  - Next edge: s1_valid=0, s2_valid=0, occupancy=0.
  - Data registers may keep stale values.
  - in_ready is forced to 0 during the flush cycle, so an input offered that cycle is not accepted.
- occupancy = s1_valid + s2_valid. It is registered-derived and updates on the same edge as the valids.
- Tables:
  - Both tables follow FIPS-197 exactly, with 256 entries each.
  - X is never output, including during and after reset.
  - INV_SBOX(SBOX(x)) = x for all x.
- rst asserted mid-operation clears everything immediately, regardless of clk, and in-flight beats are lost.

Test Plan:
- Reset and idle:
  - Stimulus: assert rst mid-stream with both stages full.
  - Required: out_valid=0, occupancy=0, out_data=0 immediately; after release in_ready=1.
- Known values, LANES=4, unstalled:
  - Forward beat: in_data=32'hFF53_0100, mode=0, tag=3.
  - Required after 2 cycles: out_data=32'h16ED_7C63, out_tag=3, out_mode=0.
  - Next-cycle inverse beat: in_data=32'h16ED_7C63, mode=1.
  - Required: out_data=32'hFF53_0100.
- Exhaustive round trip:
  - Stimulus: stream all 256 bytes, replicated across lanes, with mode=0; feed the outputs back with mode=1.
  - Required: every lane returns its original byte; 256 beats complete in 256+2 cycles at full rate.
- Backpressure:
  - Stimulus: hold out_ready=0 while offering 3 beats (tags 1, 2, 3).
  - Required: beats 1 and 2 are accepted, occupancy=2, in_ready=0, and out_data is stable with out_tag=1.
  - Stimulus: release out_ready.
  - Required: tags emerge in order 1, 2, 3 with no loss.
- Flush:
  - Stimulus: with occupancy=2, pulse flush for 1 cycle while in_valid=1.
  - Required: next cycle occupancy=0, out_valid=0, and the offered beat is not accepted (in_ready=0 during flush).
- Random traffic:
  - Stimulus: random in_valid, out_ready, mode and data with LANES=16.
  - Required: a scoreboard sees the outputs match the reference tables in order, with zero drops or duplicates.

Source files
------------

// File: rtl/aes_sbox_array.sv
// Multi-lane AES SubBytes / InvSubBytes unit: S1 captures the beat, S2 holds the
// substituted bytes. Two-stage valid/ready pipeline with per-beat mode and tag.
module aes_sbox_array #(
  parameter int LANES = 4,
  parameter int TAG_W = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_mode,
  input  logic [8*LANES-1:0]   in_data,
  input  logic [TAG_W-1:0]     in_tag,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [8*LANES-1:0]   out_data,
  output logic                 out_mode,
  output logic [TAG_W-1:0]     out_tag,
  output logic [1:0]           occupancy
);

  localparam int DATA_W = 8 * LANES;

  // Byte 0x00 occupies the most significant byte of each table.
  localparam logic [2047:0] SBOX_TBL = {
    256'h637c777bf26b6fc53001672bfed7ab76ca82c97dfa5947f0add4a2af9ca472c0,
    256'hb7fd9326363ff7cc34a5e5f171d8311504c723c31896059a071280e2eb27b275,
    256'h09832c1a1b6e5aa0523bd6b329e32f8453d100ed20fcb15b6acbbe394a4c58cf,
    256'hd0efaafb434d338545f9027f503c9fa851a3408f929d38f5bcb6da2110fff3d2,
    256'hcd0c13ec5f974417c4a77e3d645d197360814fdc222a908846eeb814de5e0bdb,
    256'he0323a0a4906245cc2d3ac629195e479e7c8376d8dd54ea96c56f4ea657aae08,
    256'hba78252e1ca6b4c6e8dd741f4bbd8b8a703eb5664803f60e613557b986c11d9e,
    256'he1f8981169d98e949b1e87e9ce5528df8ca1890dbfe6426841992d0fb054bb16
  };

  localparam logic [2047:0] INV_SBOX_TBL = {
    256'h52096ad53036a538bf40a39e81f3d7fb7ce339829b2fff87348e4344c4dee9cb,
    256'h547b9432a6c2233dee4c950b42fac34e082ea16628d924b2765ba2496d8bd125,
    256'h72f8f66486689816d4a45ccc5d65b6926c704850fdedb9da5e154657a78d9d84,
    256'h90d8ab008cbcd30af7e45805b8b34506d02c1e8fca3f0f02c1afbd0301138a6b,
    256'h3a9111414f67dcea97f2cfcef0b4e67396ac7422e7ad3585e2f937e81c75df6e,
    256'h47f11a711d29c5896fb7620eaa18be1bfc563e4bc6d279209adbc0fe78cd5af4,
    256'h1fdda8338807c731b11210592780ec5f60517fa919b54a0d2de57a9f93c99cef,
    256'ha0e03b4dae2af5b0c8ebbb3c83539961172b047eba77d626e169146355210c7d
  };

  function automatic logic [7:0] sub_byte(input logic [7:0] b, input logic inv);
    int idx;
    idx = 255 - int'(b);
    if (inv) return INV_SBOX_TBL[8*idx +: 8];
    else     return SBOX_TBL[8*idx +: 8];
  endfunction

  logic              vld_p1_q, vld_p1_d;
  logic [DATA_W-1:0] data_p1_q, data_p1_d;
  logic              mode_p1_q, mode_p1_d;
  logic [TAG_W-1:0]  tag_p1_q, tag_p1_d;
  logic              vld_p2_q, vld_p2_d;
  logic [DATA_W-1:0] data_p2_q, data_p2_d;
  logic              mode_p2_q, mode_p2_d;
  logic [TAG_W-1:0]  tag_p2_q, tag_p2_d;

  logic              s1_en, s2_en;
  logic [DATA_W-1:0] lut_p1;

  always_comb begin
    lut_p1 = '0;
    for (int i = 0; i < LANES; i++) begin
      lut_p1[8*i +: 8] = sub_byte(data_p1_q[8*i +: 8], mode_p1_q);
    end
  end

  always_comb begin
    s2_en     = !vld_p2_q || out_ready;
    s1_en     = !vld_p1_q || s2_en;
    vld_p1_d  = vld_p1_q;
    data_p1_d = data_p1_q;
    mode_p1_d = mode_p1_q;
    tag_p1_d  = tag_p1_q;
    vld_p2_d  = vld_p2_q;
    data_p2_d = data_p2_q;
    mode_p2_d = mode_p2_q;
    tag_p2_d  = tag_p2_q;
    // flush wins over every transfer; data registers are left stale
    if (flush) begin
      vld_p1_d = 1'b0;
      vld_p2_d = 1'b0;
    end else begin
      if (s1_en) begin
        vld_p1_d = in_valid;
        if (in_valid) begin
          data_p1_d = in_data;
          mode_p1_d = in_mode;
          tag_p1_d  = in_tag;
        end
      end
      if (s2_en) begin
        vld_p2_d = vld_p1_q;
        if (vld_p1_q) begin
          data_p2_d = lut_p1;
          mode_p2_d = mode_p1_q;
          tag_p2_d  = tag_p1_q;
        end
      end
    end
  end

  // Stage boundary: S1 capture and S2 lookup result
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1_q  <= 1'b0;
      data_p1_q <= '0;
      mode_p1_q <= 1'b0;
      tag_p1_q  <= '0;
      vld_p2_q  <= 1'b0;
      data_p2_q <= '0;
      mode_p2_q <= 1'b0;
      tag_p2_q  <= '0;
    end else begin
      vld_p1_q  <= vld_p1_d;
      data_p1_q <= data_p1_d;
      mode_p1_q <= mode_p1_d;
      tag_p1_q  <= tag_p1_d;
      vld_p2_q  <= vld_p2_d;
      data_p2_q <= data_p2_d;
      mode_p2_q <= mode_p2_d;
      tag_p2_q  <= tag_p2_d;
    end
  end

  assign in_ready  = s1_en && !flush;
  assign out_valid = vld_p2_q;
  assign out_data  = data_p2_q;
  assign out_mode  = mode_p2_q;
  assign out_tag   = tag_p2_q;
  assign occupancy = {1'b0, vld_p1_q} + {1'b0, vld_p2_q};

endmodule

// File: tb/tb_aes_sbox_array.sv
// Bench for aes_sbox_array (LANES=16): hand vectors, round trip, backpressure,
// flush, reset and random traffic against a GF(2^8)-derived reference.
module tb_aes_sbox_array;

  localparam int LANES = 16;
  localparam int TAG_W = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         flush = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic         in_mode = 1'b0;
  logic [127:0] in_data = '0;
  logic [3:0]   in_tag = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [127:0] out_data;
  logic         out_mode;
  logic [3:0]   out_tag;
  logic [1:0]   occupancy;

  aes_sbox_array #(.LANES(LANES), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode),
    .in_data(in_data), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_mode(out_mode), .out_tag(out_tag), .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: S-box from multiplicative inverse in GF(2^8) plus affine map.
  logic [7:0] fwd_tbl [256];
  logic [7:0] inv_tbl [256];

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    logic [7:0] y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  task automatic build_tables();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv = 8'h00;
      logic [7:0] s;
      for (int y = 1; y < 256; y++)
        if (gf_mul(x[7:0], y[7:0]) == 8'h01) inv = y[7:0];
      s = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
      fwd_tbl[x] = s;
    end
    for (int x = 0; x < 256; x++) inv_tbl[fwd_tbl[x]] = x[7:0];
  endtask

  function automatic logic [127:0] model(input logic [127:0] d, input logic m);
    logic [127:0] r;
    for (int i = 0; i < LANES; i++)
      r[8*i +: 8] = m ? inv_tbl[d[8*i +: 8]] : fwd_tbl[d[8*i +: 8]];
    return r;
  endfunction

  typedef struct {
    logic [127:0] d;
    logic         m;
    logic [3:0]   t;
  } beat_t;

  beat_t      exp_q [$];
  logic [3:0] obs_tags [$];

  // Scoreboard: every accepted beat must emerge once, in order, transformed.
  always @(negedge clk) begin
    if (rst || flush) begin
      exp_q.delete();
    end else begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("sb_extra_beat", 128'(out_tag), 128'hx);
        end else begin
          beat_t e;
          e = exp_q.pop_front();
          check("sb_data", out_data, e.d);
          check("sb_mode_tag", 128'({out_mode, out_tag}), 128'({e.m, e.t}));
          obs_tags.push_back(out_tag);
        end
      end
      if (in_valid && in_ready) begin
        beat_t b;
        b.d = model(in_data, in_mode);
        b.m = in_mode;
        b.t = in_tag;
        exp_q.push_back(b);
      end
    end
  end

  task automatic send_beat(input logic [127:0] d, input logic m, input logic [3:0] t);
    bit acc = 0;
    in_valid = 1'b1; in_data = d; in_mode = m; in_tag = t;
    for (int k = 0; k < 50 && !acc; k++) begin
      @(negedge clk);
      if (in_ready) acc = 1;
      @(posedge clk); #1;
    end
    if (!acc) begin
      n_cmp++; n_fail++;
      $display("FAIL send_timeout: tag %0d never accepted", t);
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    for (int k = 0; k < 20; k++) begin
      @(posedge clk);
      if (exp_q.size() == 0) break;
    end
    #1;
    check(name, 128'(exp_q.size()), 128'd0);
  endtask

  typedef struct {
    logic         m;
    logic [3:0]   t;
    logic [127:0] din;
    logic [127:0] exp;
  } vec_t;

  vec_t vecs [4];
  logic [127:0] rt_mid  [256];
  logic [127:0] rt_back [256];

  initial begin
    int got;
    build_tables();
    vecs[0] = '{1'b0, 4'd3, {96'h0, 32'hFF53_0100}, {{12{8'h63}}, 32'h16ED_7C63}};
    vecs[1] = '{1'b1, 4'd4, {{12{8'h63}}, 32'h16ED_7C63}, {96'h0, 32'hFF53_0100}};
    vecs[2] = '{1'b0, 4'd5, 128'h00112233445566778899aabbccddeeff,
                128'h638293c31bfc33f5c4eeacea4bc12816};
    vecs[3] = '{1'b1, 4'd6, 128'h00112233445566778899aabbccddeeff,
                128'h52e3946686edd30297f962fe27c9997d};

    // Reset and idle
    #1 rst = 1'b1;
    #1;
    check("rst_out_valid", 128'(out_valid), 128'd0);
    check("rst_occupancy", 128'(occupancy), 128'd0);
    check("rst_out_data", out_data, 128'd0);
    check("rst_out_mode_tag", 128'({out_mode, out_tag}), 128'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1 check("rst_in_ready", 128'(in_ready), 128'd1);

    // Known vectors, back to back with alternating mode
    @(posedge clk); #1;
    for (int cyc = 0; cyc < 6; cyc++) begin
      if (cyc < 4) begin
        in_valid = 1'b1; in_mode = vecs[cyc].m; in_tag = vecs[cyc].t; in_data = vecs[cyc].din;
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      if (cyc < 2) begin
        check("vec_latency", 128'(out_valid), 128'd0);
      end else begin
        check("vec_valid", 128'(out_valid), 128'd1);
        check("vec_data", out_data, vecs[cyc-2].exp);
        check("vec_mode_tag", 128'({out_mode, out_tag}), 128'({vecs[cyc-2].m, vecs[cyc-2].t}));
      end
      @(posedge clk); #1;
    end

    // Exhaustive round trip at full rate
    for (int pass = 0; pass < 2; pass++) begin
      got = 0;
      for (int cyc = 0; cyc < 258; cyc++) begin
        if (cyc < 256) begin
          in_valid = 1'b1;
          in_mode  = (pass == 1);
          in_tag   = cyc[3:0];
          in_data  = (pass == 1) ? rt_mid[cyc] : {16{cyc[7:0]}};
        end else begin
          in_valid = 1'b0;
        end
        @(negedge clk);
        if (out_valid && got < 256) begin
          if (pass == 0) rt_mid[got] = out_data;
          else           rt_back[got] = out_data;
          got++;
        end
        @(posedge clk); #1;
      end
      check("rt_beats_in_258", 128'(got), 128'd256);
    end
    for (int i = 0; i < 256; i++) check("rt_identity", rt_back[i], {16{i[7:0]}});

    // Backpressure
    out_ready = 1'b0;
    send_beat(128'h0123456789abcdef0011223344556677, 1'b0, 4'd1);
    send_beat(128'hfedcba98765432100f1e2d3c4b5a6978, 1'b1, 4'd2);
    in_valid = 1'b1; in_data = 128'h3; in_mode = 1'b0; in_tag = 4'd3;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("bp_in_ready", 128'(in_ready), 128'd0);
      check("bp_occupancy", 128'(occupancy), 128'd2);
      check("bp_out_tag", 128'(out_tag), 128'd1);
      check("bp_out_data", out_data, model(128'h0123456789abcdef0011223344556677, 1'b0));
      @(posedge clk); #1;
    end
    obs_tags.delete();
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_release_ready", 128'(in_ready), 128'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_drain("bp_drain");
    check("bp_tag_count", 128'(obs_tags.size()), 128'd3);
    if (obs_tags.size() == 3)
      check("bp_tag_order", 128'({obs_tags[0], obs_tags[1], obs_tags[2]}), 128'h123);

    // Flush with both stages full and a beat offered
    out_ready = 1'b0;
    send_beat(128'h77, 1'b0, 4'd7);
    send_beat(128'h88, 1'b1, 4'd8);
    in_valid = 1'b1; in_data = 128'h99; in_mode = 1'b0; in_tag = 4'd9;
    flush = 1'b1;
    @(negedge clk);
    check("fl_occ_before", 128'(occupancy), 128'd2);
    check("fl_in_ready", 128'(in_ready), 128'd0);
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check("fl_occupancy", 128'(occupancy), 128'd0);
    check("fl_out_valid", 128'(out_valid), 128'd0);
    out_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("fl_no_leak", 128'(out_valid), 128'd0);
    end
    @(posedge clk); #1;

    // Asynchronous reset mid-stream
    out_ready = 1'b0;
    send_beat(128'haa, 1'b0, 4'd10);
    send_beat(128'hbb, 1'b1, 4'd11);
    @(negedge clk);
    check("ar_occ_before", 128'(occupancy), 128'd2);
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    check("ar_out_valid", 128'(out_valid), 128'd0);
    check("ar_occupancy", 128'(occupancy), 128'd0);
    check("ar_out_data", out_data, 128'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1 check("ar_in_ready", 128'(in_ready), 128'd1);
    out_ready = 1'b1;
    @(posedge clk); #1;

    // Random traffic
    for (int cyc = 0; cyc < 3000; cyc++) begin
      in_valid  = ($urandom % 4) != 0;
      out_ready = ($urandom % 4) != 0;
      in_mode   = $urandom % 2;
      in_tag    = 4'($urandom);
      in_data   = {$urandom, $urandom, $urandom, $urandom};
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    wait_drain("rand_drain");
    check("rand_idle_occ", 128'(occupancy), 128'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1, "timeout");
  end

endmodule
